// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I write-back stage: MEM/WB register, load extraction, result select, retire counter
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_rf_we,
    input  logic [4:0]  mem_rd,
    input  logic [1:0]  mem_wb_sel,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_imm,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] retire_cnt
);

    logic        valid_q;
    logic        we_q;
    logic [4:0]  rd_q;
    logic [1:0]  sel_q;
    logic [2:0]  funct3_q;
    logic [31:0] alu_q;
    logic [31:0] rdata_q;
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic        counted;
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            rd_q     <= 5'd0;
            sel_q    <= 2'b00;
            funct3_q <= 3'd0;
            alu_q    <= 32'd0;
            rdata_q  <= 32'd0;
            pc_q     <= 32'd0;
            imm_q    <= 32'd0;
            counted  <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            // An instruction is counted on the first edge it sits in WB, whatever happens to it next
            if (valid_q && !counted) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (flush) begin
                valid_q <= 1'b0;
                we_q    <= 1'b0;
                counted <= 1'b0;
            end else if (stall) begin
                counted <= valid_q;
            end else begin
                valid_q  <= mem_valid;
                we_q     <= mem_rf_we;
                rd_q     <= mem_rd;
                sel_q    <= mem_wb_sel;
                funct3_q <= mem_funct3;
                alu_q    <= mem_alu_res;
                rdata_q  <= mem_rdata;
                pc_q     <= mem_pc;
                imm_q    <= mem_imm;
                counted  <= 1'b0;
            end
        end
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    always_comb begin
        load_byte = 8'd0;
        case (alu_q[1:0])
            2'd0: load_byte = rdata_q[7:0];
            2'd1: load_byte = rdata_q[15:8];
            2'd2: load_byte = rdata_q[23:16];
            2'd3: load_byte = rdata_q[31:24];
            default: load_byte = 8'd0;
        endcase
        load_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_q)
            3'b000: load_data = {{24{load_byte[7]}}, load_byte};
            3'b001: load_data = {{16{load_half[15]}}, load_half};
            3'b100: load_data = {24'd0, load_byte};
            3'b101: load_data = {16'd0, load_half};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        rf_wd = 32'd0;
        case (sel_q)
            2'b00: rf_wd = alu_q;
            2'b01: rf_wd = load_data;
            2'b10: rf_wd = pc_q + 32'd4;
            2'b11: rf_wd = imm_q;
            default: rf_wd = 32'd0;
        endcase
    end

    assign rf_we      = valid_q & we_q & (rd_q != 5'd0);
    assign rf_wa      = rd_q;
    assign wb_valid   = valid_q;
    assign wb_pc      = pc_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_rf_we;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_res, mem_rdata, mem_pc, mem_imm;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_rf_we(mem_rf_we), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_alu_res(mem_alu_res),
        .mem_rdata(mem_rdata), .mem_pc(mem_pc), .mem_imm(mem_imm),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .retire_cnt(retire_cnt)
    );

    task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc, input logic [31:0] imm);
        mem_valid = v; mem_rf_we = we; mem_rd = rd; mem_wb_sel = sel; mem_funct3 = f3;
        mem_alu_res = alu; mem_rdata = rdata; mem_pc = pc; mem_imm = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 5'd9, 2'b10, 3'd0, 32'hDEAD_BEEF, 32'h1111_2222, 32'h100, 32'h5000);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we actual=%b required=0", rf_we); end
        checks++; if (rf_wa !== 5'd0) begin errors++; $display("FAIL reset_rf_wa actual=%0d required=0", rf_wa); end
        checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_wd actual=%h required=0", rf_wd); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid actual=%b required=0", wb_valid); end
        checks++; if (wb_pc !== 32'd0) begin errors++; $display("FAIL reset_wb_pc actual=%h required=0", wb_pc); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire_cnt actual=%0d required=0", retire_cnt); end
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'd0, 32'h0000_1234, 32'h0, 32'h0000_0040, 32'h0);
        step();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_rf_we actual=%b required=1", rf_we); end
        checks++; if (rf_wa !== 5'd5) begin errors++; $display("FAIL alu_rf_wa actual=%0d required=5", rf_wa); end
        checks++; if (rf_wd !== 32'h0000_1234) begin errors++; $display("FAIL alu_rf_wd actual=%h required=00001234", rf_wd); end
        checks++; if (wb_pc !== 32'h0000_0040) begin errors++; $display("FAIL alu_wb_pc actual=%h required=00000040", wb_pc); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL alu_cnt_before actual=%0d required=0", retire_cnt); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [7] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off [7] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [31:0] exp [7] = '{32'hFFFF_FF80, 32'hFFFF_FFF2, 32'h0000_007F, 32'hFFFF_8081,
                                 32'hFFFF_8081, 32'h0000_F27F, 32'h8081_F27F};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 5'd10, 2'b01, f3[i], {30'h0000_2000, off[i]}, 32'h8081_F27F, 32'h0, 32'h0);
            step();
            checks++;
            if (rf_wd !== exp[i]) begin
                errors++; $display("FAIL load_%0d_rf_wd actual=%h required=%h", i, rf_wd, exp[i]);
            end
            checks++;
            if (retire_cnt !== 32'(i + 1)) begin
                errors++; $display("FAIL load_%0d_cnt actual=%0d required=%0d", i, retire_cnt, i + 1);
            end
        end
    endtask

    task automatic test_jal_lui_x0();
        drive(1'b1, 1'b1, 5'd1, 2'b10, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        step();
        checks++; if (rf_wd !== 32'h0000_0000) begin errors++; $display("FAIL jal_rf_wd actual=%h required=00000000", rf_wd); end
        checks++; if (rf_wa !== 5'd1) begin errors++; $display("FAIL jal_rf_wa actual=%0d required=1", rf_wa); end
        drive(1'b1, 1'b1, 5'd2, 2'b11, 3'd0, 32'h0, 32'h0, 32'h0, 32'hABCD_E000);
        step();
        checks++; if (rf_wd !== 32'hABCD_E000) begin errors++; $display("FAIL lui_rf_wd actual=%h required=abcde000", rf_wd); end
        checks++; if (retire_cnt !== 32'd9) begin errors++; $display("FAIL lui_cnt actual=%0d required=9", retire_cnt); end
        drive(1'b1, 1'b1, 5'd0, 2'b00, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0);
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_rf_we actual=%b required=0", rf_we); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL x0_wb_valid actual=%b required=1", wb_valid); end
        checks++; if (retire_cnt !== 32'd10) begin errors++; $display("FAIL x0_cnt actual=%0d required=10", retire_cnt); end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 1'b1, 5'd7, 2'b00, 3'd0, 32'h0000_0055, 32'h0, 32'h0000_0200, 32'h0);
        step();
        checks++; if (retire_cnt !== 32'd11) begin errors++; $display("FAIL pre_stall_cnt actual=%0d required=11", retire_cnt); end
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 2'b11, 3'd0, 32'h9999, 32'h0, 32'h0, 32'hFFFF_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h0000_0055) begin
                errors++; $display("FAIL stall_%0d_hold actual=%b/%0d/%h required=1/7/00000055", i, rf_we, rf_wa, rf_wd);
            end
            checks++;
            if (retire_cnt !== 32'd12) begin
                errors++; $display("FAIL stall_%0d_cnt actual=%0d required=12", i, retire_cnt);
            end
        end
        flush = 1'b1;
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid actual=%b required=0", wb_valid); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_rf_we actual=%b required=0", rf_we); end
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        checks++; if (retire_cnt !== 32'd12) begin errors++; $display("FAIL post_flush_cnt actual=%0d required=12", retire_cnt); end
    endtask

    task automatic test_reset_during_stall();
        drive(1'b1, 1'b1, 5'd3, 2'b01, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 32'h0000_0300, 32'h0);
        step();
        checks++; if (rf_wd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_stall_load_wd actual=%h required=cafef00d", rf_wd); end
        stall = 1'b1;
        step();
        checks++; if (retire_cnt !== 32'd13) begin errors++; $display("FAIL rst_stall_cnt actual=%0d required=13", retire_cnt); end
        rst = 1'b1;
        step();
        checks++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0 || wb_valid !== 1'b0 || wb_pc !== 32'd0) begin
            errors++; $display("FAIL rst_stall_outputs actual=%b/%0d/%h/%b/%h required=0/0/00000000/0/00000000",
                               rf_we, rf_wa, rf_wd, wb_valid, wb_pc);
        end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt_zero actual=%0d required=0", retire_cnt); end
        rst = 1'b0; stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_no_count actual=%0d required=0", retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_jal_lui_x0();
        test_stall_flush();
        test_reset_during_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage RV32I pipeline: the MEM/WB pipeline register plus the write-back selection and load-data extraction logic that drives the register file write port (`we`/`wa`/`wd`). It sits directly upstream of the register file and directly downstream of the data memory stage. It also exposes a retired-instruction counter for the debug bus.

## Interface
- No parameters; all widths fixed (RV32I, 32 registers).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold the WB register contents.
- `flush` in 1: load a bubble into the WB register.
- `mem_valid` in 1: MEM stage holds a real instruction.
- `mem_rf_we` in 1: instruction writes rd.
- `mem_rd` in 5: destination register.
- `mem_wb_sel` in 2: 00 ALU result, 01 load data, 10 PC+4, 11 immediate (lui).
- `mem_funct3` in 3: load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- `mem_alu_res` in 32: ALU result / load address.
- `mem_rdata` in 32: raw word read from data memory (word-aligned).
- `mem_pc` in 32: instruction PC.
- `mem_imm` in 32: immediate.
- `rf_we` out 1: register file write enable.
- `rf_wa` out 5: register file write address.
- `rf_wd` out 32: register file write data.
- `wb_valid` out 1: WB register holds a real instruction.
- `wb_pc` out 32: PC of the instruction in WB.
- `retire_cnt` out 32: count of instructions retired since reset.

## Operation
- WB register fields: valid, rf_we, rd, wb_sel, funct3, alu_res, rdata, pc, imm, plus internal `counted` flag.
- Update priority per edge: `rst` > `flush` > `stall` > capture.
  - `rst`: all fields 0, `retire_cnt` 0, `counted` 0.
  - `flush` (stall ignored): valid 0, rf_we 0, other fields don't-care; `counted` 0.
  - `stall`: all fields hold; `counted` set to 1 if valid.
  - capture: all fields load from `mem_*`; `counted` 0.
- `rf_we` = valid & rf_we field & (rd != 0). Never asserted for x0 or bubbles.
- `rf_wa` = rd field; `wb_valid` = valid; `wb_pc` = pc field.
- `rf_wd` by wb_sel: alu_res; load data; pc + 4 (32-bit wrap); imm.
- Load extraction, offset = alu_res[1:0]:
  - lb/lbu: byte at bits [8·offset+7 : 8·offset], sign-/zero-extended.
  - lh/lhu: halfword selected by offset[1] (offset[0] ignored; misaligned halfwords are not trapped), sign-/zero-extended.
  - lw: whole word; offset ignored.
  - Other funct3 codes: whole word.
- `retire_cnt` increments by 1 on any edge where valid=1 and `counted`=0 and not `rst`. A stalled instruction counts exactly once. Wraps at 2^32−1 → 0.

## Timing
- Combinational outputs (`rf_we`, `rf_wa`, `rf_wd`) derive from registered state only; no combinational path from any `mem_*` input.
- Latency: MEM inputs sampled at edge N appear on `rf_*` during cycle N..N+1. The register file commits at edge N+1. Its write-first read path makes the value visible to decode in that same cycle.
- During a stall, `rf_we` stays asserted with identical `wa`/`wd` (idempotent rewrite).
- Reset values: `rf_we` 0, `rf_wa` 0, `rf_wd` 0 (wb_sel 00, alu_res 0), `wb_valid` 0, `wb_pc` 0, `retire_cnt` 0.
- Reset asserted mid-stall discards the held instruction. It is neither written nor counted after the reset edge.
- `flush` and `stall` asserted together: flush wins.

## Test plan
- Reset, then capture valid add writing x5 with alu_res 0x0000_1234 → next cycle `rf_we`=1, `rf_wa`=5, `rf_wd`=0x0000_1234; `retire_cnt` becomes 1.
- Loads with rdata 0x8081_F27F: lb offset 3 → 0xFFFF_FF80; lbu offset 0 → 0x0000_007F; lh offset 2 → 0xFFFF_8081; lhu offset 0 → 0x0000_F27F; lw offset 1 → 0x8081_F27F.
- jal with wb_sel 10, pc 0xFFFF_FFFC, rd x1 → `rf_wd`=0x0000_0000. lui with wb_sel 11, imm 0xABCD_E000 → `rf_wd`=0xABCD_E000.
- Instruction with rd x0 and mem_rf_we=1 → `rf_we`=0, `wb_valid`=1, `retire_cnt` increments.
- Valid instruction held by `stall` for 3 cycles → `rf_we`/`rf_wd` stable all 3 cycles; `retire_cnt` increments once. Then `stall`+`flush` together → `wb_valid`=0, `rf_we`=0.
- `rst` asserted while a valid load is held by stall → next cycle all outputs zero; `retire_cnt`=0.
